aurora_rx_post_fifo: RTL and testbench
======================================

// Module: aurora_rx_post_fifo
// PURPOSE
//  Parametrised RTDS-over-Aurora receive post-processor, sitting between the Aurora RX AXI-Stream
//  master (no tready) and the fabric AXI-Stream consumer.
//  - Counts frames and words per frame.
//  - Optionally strips the trailing sequence word, regenerating tlast on the last data word.
//  - Checks sequence continuity.
//  - Adds consumer backpressure through an internal FIFO, with overflow accounting.
// PARAMETERS
//  DATA_W      32  stream data width (bits)
//  FIFO_DEPTH  16  output FIFO depth (words); power of two, >= 4
//  SEQ_W       32  sequence field width, taken from s_axis_tdata[SEQ_W-1:0]; SEQ_W <= DATA_W
//  PKT_CNT_W   16  words-per-frame counter width
//  CNT_W       64  frame / drop counter width
// PORTS
//  m_axis_aclk        in   1          sole clock
//  m_axis_areset      in   1          synchronous reset, active-high
//  s_axis_tvalid      in   1          input word valid (Aurora; no tready, every valid word is offered once)
//  s_axis_tdata       in   DATA_W     input data
//  s_axis_tlast       in   1          last word of frame (the sequence word when stripping)
//  m_axis_tvalid      out  1          output word valid
//  m_axis_tready      in   1          consumer ready
//  m_axis_tdata       out  DATA_W     output data
//  m_axis_tlast       out  1          last data word of frame
//  ctrl_strip_seq_en  in   1          1 = remove trailing sequence word; sampled per frame
//  ctrl_rst_cntr_in   in   1          level: clears counters/flags while high
//  stat_frame_cnt     out  CNT_W      frames received (tvalid & tlast)
//  stat_pkt_cnt       out  PKT_CNT_W  data words in last complete frame (excl. sequence word if stripped)
//  stat_pkt_cnt_vld   out  1          one-cycle pulse when stat_pkt_cnt updates
//  stat_seq_err_cnt   out  32         sequence discontinuities, saturating
//  stat_drop_cnt      out  CNT_W      words dropped on FIFO full
//  stat_ovf           out  1          sticky: at least one drop since last clear
// BEHAVIOUR
//  Reset
//  - All outputs 0; FIFO empty; hold stage empty; sequence baseline invalid.
//  Frame mode
//  - ctrl_strip_seq_en is latched on the first valid word of each frame; changes mid-frame apply from the next frame.
//  Pass mode (strip=0)
//  - Each input word is written to the FIFO with its own tlast.
//  - Latency: in at cycle N -> m_axis_tvalid at N+1 (FWFT).
//  Strip mode (strip=1): one-word hold register
//  - Non-last word: if hold is full, write hold (tlast=0) to FIFO; hold <= word.
//  - Last word: if hold is full, write hold with tlast=1 to FIFO and empty hold. The sequence word itself is never written.
//  - Single-word frame (sequence word only): nothing written, no tlast emitted; frame still counted, stat_pkt_cnt=0.
//  Output handshake
//  - Standard AXI-S: word leaves on tvalid&tready.
//  - tdata/tlast stable while tvalid&!tready.
//  FIFO full on a write
//  - Word discarded; stat_drop_cnt+1; stat_ovf<=1.
//  - A discarded tlast word is not re-marked on any other word.
//  - Simultaneous read and write when full: the read frees space first and the write succeeds.
//  Sequence check (strip mode only, on each sequence word)
//  - Baseline invalid: store the value, no error.
//  - Otherwise: error if seq != expected+1 mod 2^SEQ_W.
//  - Expected <= received seq in both cases.
//  stat_pkt_cnt
//  - Registered the cycle after the tlast word; stat_pkt_cnt_vld pulses in that same cycle.
//  - Per-frame word counter saturates at 2^PKT_CNT_W-1.
//  stat_frame_cnt
//  - +1 per tvalid&tlast; wraps at 2^CNT_W.
//  ctrl_rst_cntr_in high
//  - Clears frame/drop/seq-err counters, stat_ovf and the sequence baseline; they stay at 0 while high.
//  - A frame ending in the same cycle as the clear is not counted.
//  - FIFO and data path are unaffected.
//  Reset mid-frame
//  - Partial frame, hold and FIFO contents discarded.
//  - The next word is treated as the start of a new frame.
// STRUCTURE
//  - Package aurora_post_pkg: FIFO word type {tlast, tdata}; localparams S_IDLE/S_IN_FRAME; SEQ_ERR_W=32.
//  - Sub-module axis_sync_fifo: single-clock FWFT, width DATA_W+1, depth FIFO_DEPTH; full/empty flags.
//  - Top holds: frame FSM (S_IDLE: no frame open; S_IN_FRAME: after first word, back on tlast), hold register, counters.
// TESTING
//  1 strip=0, frame A,B,C(tlast), tready=1 -> A,B,C out at N+1 each, tlast on C; frame_cnt=1, pkt_cnt=3.
//  2 strip=1, frames {A,B,seq=5},{C,seq=6},{seq=8} -> A,B(tlast),C(tlast) out; seq_err_cnt=1; last pkt_cnt=0.
//  3 strip=0, tready=0, 20 single-word frames, FIFO_DEPTH=16 -> 16 accepted, drop_cnt=4, ovf=1; then tready=1 drains 16.
//  4 FIFO full with tready=1 and an input word in the same cycle -> no drop; output order preserved.
//  5 ctrl_rst_cntr_in pulsed mid-stream -> counters 0; first seq after release sets baseline, no error.
//  6 reset asserted mid-frame (strip=1, hold full) -> m_axis_tvalid=0 next cycle; next frame output intact.

Source files
------------

// File: rtl/aurora_post_pkg.sv
// Shared types and helpers for the Aurora RX post-processor.
package aurora_post_pkg;

    // Width of the saturating sequence-error counter.
    localparam int SEQ_ERR_W = 32;

    // Frame tracking: S_IDLE = no frame open, S_IN_FRAME = first word seen, waiting for tlast.
    typedef enum logic {
        S_IDLE     = 1'b0,
        S_IN_FRAME = 1'b1
    } frame_state_t;

    // Saturating increment for the sequence-error counter.
    function automatic logic [SEQ_ERR_W-1:0] sat_inc_err(input logic [SEQ_ERR_W-1:0] v);
        return (v == {SEQ_ERR_W{1'b1}}) ? v : v + SEQ_ERR_W'(1);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A read in the same cycle as a write
// to a full FIFO frees the slot first, so the write is accepted.
module axis_sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         rd_ok;
    logic         wr_ok;

    // Flags, handshake qualification and pointer advance.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aurora_rx_post_fifo.sv
// Aurora RX post-processor: frame/word accounting, optional trailing sequence-word
// strip with tlast regeneration, sequence continuity check, and an output FIFO
// that adds consumer backpressure to a source that cannot be stalled.
module aurora_rx_post_fifo
    import aurora_post_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int SEQ_W      = 32,
    parameter int PKT_CNT_W  = 16,
    parameter int CNT_W      = 64
) (
    input  logic                 m_axis_aclk,
    input  logic                 m_axis_areset,
    input  logic                 s_axis_tvalid,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tlast,
    input  logic                 ctrl_strip_seq_en,
    input  logic                 ctrl_rst_cntr_in,
    output logic [CNT_W-1:0]     stat_frame_cnt,
    output logic [PKT_CNT_W-1:0] stat_pkt_cnt,
    output logic                 stat_pkt_cnt_vld,
    output logic [SEQ_ERR_W-1:0] stat_seq_err_cnt,
    output logic [CNT_W-1:0]     stat_drop_cnt,
    output logic                 stat_ovf
);

    typedef struct packed {
        logic              tlast;
        logic [DATA_W-1:0] tdata;
    } fifo_word_t;

    function automatic logic [PKT_CNT_W-1:0] sat_inc_pkt(input logic [PKT_CNT_W-1:0] v);
        return (v == {PKT_CNT_W{1'b1}}) ? v : v + PKT_CNT_W'(1);
    endfunction

    frame_state_t          state_q, state_d;
    logic                  strip_q, strip_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0]     hold_data_q, hold_data_d;
    logic [PKT_CNT_W-1:0]  wc_q, wc_d;
    logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  pkt_vld_q, pkt_vld_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [SEQ_ERR_W-1:0]  seq_err_q, seq_err_d;
    logic                  ovf_q, ovf_d;
    logic                  base_vld_q, base_vld_d;
    logic [SEQ_W-1:0]      exp_seq_q, exp_seq_d;

    logic                  strip_cur;
    logic [SEQ_W-1:0]      seq_in;
    logic [SEQ_W-1:0]      seq_next;
    logic                  wr_en;
    fifo_word_t            wr_word;
    fifo_word_t            rd_word;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rd_en;

    // Frame FSM, hold register, FIFO write selection and all statistics.
    always_comb begin
        state_d     = state_q;
        strip_d     = strip_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        wc_d        = wc_q;
        pkt_cnt_d   = pkt_cnt_q;
        pkt_vld_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        seq_err_d   = seq_err_q;
        ovf_d       = ovf_q;
        base_vld_d  = base_vld_q;
        exp_seq_d   = exp_seq_q;
        wr_en       = 1'b0;
        wr_word     = '0;

        // The strip mode of the first word of a frame comes straight from the control input.
        strip_cur = (state_q == S_IDLE) ? ctrl_strip_seq_en : strip_q;
        seq_in    = s_axis_tdata[SEQ_W-1:0];
        seq_next  = exp_seq_q + SEQ_W'(1);
        rd_en     = !fifo_empty && m_axis_tready;

        if (s_axis_tvalid) begin
            if (state_q == S_IDLE) strip_d = ctrl_strip_seq_en;

            if (s_axis_tlast) begin
                state_d     = S_IDLE;
                wc_d        = '0;
                pkt_vld_d   = 1'b1;
                pkt_cnt_d   = strip_cur ? wc_q : sat_inc_pkt(wc_q);
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                state_d = S_IN_FRAME;
                wc_d    = sat_inc_pkt(wc_q);
            end

            if (strip_cur) begin
                // The held word goes out once we know whether it is the last data word.
                if (hold_vld_q) begin
                    wr_en   = 1'b1;
                    wr_word = '{tlast: s_axis_tlast, tdata: hold_data_q};
                end
                if (s_axis_tlast) begin
                    hold_vld_d = 1'b0;
                    if (base_vld_q && (seq_in != seq_next)) seq_err_d = sat_inc_err(seq_err_q);
                    base_vld_d = 1'b1;
                    exp_seq_d  = seq_in;
                end else begin
                    hold_vld_d  = 1'b1;
                    hold_data_d = s_axis_tdata;
                end
            end else begin
                wr_en   = 1'b1;
                wr_word = '{tlast: s_axis_tlast, tdata: s_axis_tdata};
            end
        end

        // A write to a full FIFO is lost unless a read frees a slot in the same cycle.
        if (wr_en && fifo_full && !rd_en) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            ovf_d      = 1'b1;
        end

        if (ctrl_rst_cntr_in) begin
            frame_cnt_d = '0;
            drop_cnt_d  = '0;
            seq_err_d   = '0;
            ovf_d       = 1'b0;
            base_vld_d  = 1'b0;
        end
    end

    // State and statistics registers.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q     <= S_IDLE;
            strip_q     <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            wc_q        <= '0;
            pkt_cnt_q   <= '0;
            pkt_vld_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            seq_err_q   <= '0;
            ovf_q       <= 1'b0;
            base_vld_q  <= 1'b0;
            exp_seq_q   <= '0;
        end else begin
            state_q     <= state_d;
            strip_q     <= strip_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            wc_q        <= wc_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pkt_vld_q   <= pkt_vld_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            seq_err_q   <= seq_err_d;
            ovf_q       <= ovf_d;
            base_vld_q  <= base_vld_d;
            exp_seq_q   <= exp_seq_d;
        end
    end

    axis_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (m_axis_aclk),
        .rst     (m_axis_areset),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output drive; data is forced to zero while nothing is presented.
    always_comb begin
        m_axis_tvalid    = !fifo_empty;
        m_axis_tdata     = fifo_empty ? '0 : rd_word.tdata;
        m_axis_tlast     = fifo_empty ? 1'b0 : rd_word.tlast;
        stat_frame_cnt   = frame_cnt_q;
        stat_pkt_cnt     = pkt_cnt_q;
        stat_pkt_cnt_vld = pkt_vld_q;
        stat_seq_err_cnt = seq_err_q;
        stat_drop_cnt    = drop_cnt_q;
        stat_ovf         = ovf_q;
    end

endmodule

// File: tb/tb_aurora_rx_post_fifo.sv
// Scoreboard bench for aurora_rx_post_fifo: directed frames with hand-computed outputs.
module tb_aurora_rx_post_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        strip_en = 1'b0;
    logic        rst_cntr = 1'b0;
    logic [63:0] frame_cnt;
    logic [15:0] pkt_cnt;
    logic        pkt_vld;
    logic [31:0] seq_err;
    logic [63:0] drop_cnt;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    aurora_rx_post_fifo dut (
        .m_axis_aclk       (clk),
        .m_axis_areset     (rst),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tdata      (s_tdata),
        .s_axis_tlast      (s_tlast),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tlast      (m_tlast),
        .ctrl_strip_seq_en (strip_en),
        .ctrl_rst_cntr_in  (rst_cntr),
        .stat_frame_cnt    (frame_cnt),
        .stat_pkt_cnt      (pkt_cnt),
        .stat_pkt_cnt_vld  (pkt_vld),
        .stat_seq_err_cnt  (seq_err),
        .stat_drop_cnt     (drop_cnt),
        .stat_ovf          (ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Offer one word; it is sampled on the next rising edge.
    task automatic send(input logic [31:0] d, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every word the consumer takes is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected actual=%0h expected=none", {m_tlast, m_tdata});
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== e) begin
                    failures++;
                    $display("FAIL out_word actual=%0h expected=%0h", {m_tlast, m_tdata}, e);
                end
            end
        end
    end

    initial begin
        idle(3);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        idle(1);

        // 1: pass mode, FWFT latency
        m_tready = 1'b1;
        push(32'hA, 0); push(32'hB, 0); push(32'hC, 1);
        send(32'hA, 0);
        chk("t1_lat_valid", m_tvalid, 1);
        chk("t1_lat_data", m_tdata, 32'hA);
        send(32'hB, 0);
        send(32'hC, 1);
        chk("t1_pkt_vld", pkt_vld, 1);
        chk("t1_pkt_cnt", pkt_cnt, 3);
        chk("t1_frame", frame_cnt, 1);
        idle(1);
        chk("t1_pkt_vld_pulse", pkt_vld, 0);
        idle(2);

        // 2: strip mode, strip change mid-frame ignored, sequence check
        strip_en = 1'b1;
        push(32'h1111_0001, 0); push(32'h1111_0002, 1); push(32'h1111_0003, 1);
        send(32'h1111_0001, 0);
        send(32'h1111_0002, 0);
        send(32'd5, 1);
        chk("t2_pkt_ab", pkt_cnt, 2);
        send(32'h1111_0003, 0);
        strip_en = 1'b0;
        send(32'd6, 1);
        chk("t2_pkt_c", pkt_cnt, 1);
        chk("t2_seq_ok", seq_err, 0);
        strip_en = 1'b1;
        send(32'd8, 1);
        chk("t2_pkt_seq_only", pkt_cnt, 0);
        chk("t2_seq_err", seq_err, 1);
        chk("t2_frame", frame_cnt, 4);
        idle(3);
        chk("t2_drained", exp_q.size(), 0);

        // 3: overflow with consumer stalled
        strip_en = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) push(32'h300 + i, 1);
            send(32'h300 + i, 1);
        end
        chk("t3_drop", drop_cnt, 4);
        chk("t3_ovf", ovf, 1);
        chk("t3_frame", frame_cnt, 24);
        m_tready = 1'b1;
        idle(20);
        chk("t3_drained", exp_q.size(), 0);

        // 4: simultaneous read and write while full
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(32'h400 + i, 0);
            send(32'h400 + i, 0);
        end
        m_tready = 1'b1;
        push(32'h410, 1);
        send(32'h410, 1);
        chk("t4_no_drop", drop_cnt, 4);
        chk("t4_pkt", pkt_cnt, 17);
        idle(20);
        chk("t4_drained", exp_q.size(), 0);

        // 5: counter clear mid-stream; data path untouched
        rst_cntr = 1'b1;
        push(32'h500, 1);
        send(32'h500, 1);
        idle(1);
        chk("t5_frame_clr", frame_cnt, 0);
        chk("t5_drop_clr", drop_cnt, 0);
        chk("t5_ovf_clr", ovf, 0);
        chk("t5_seq_clr", seq_err, 0);
        rst_cntr = 1'b0;
        strip_en = 1'b1;
        push(32'h5D, 1);
        send(32'h5D, 0);
        send(32'd100, 1);
        chk("t5_baseline", seq_err, 0);
        send(32'd101, 1);
        chk("t5_seq_ok", seq_err, 0);
        send(32'd200, 1);
        chk("t5_seq_err", seq_err, 1);
        chk("t5_frame", frame_cnt, 3);
        idle(3);
        chk("t5_drained", exp_q.size(), 0);

        // 6: reset mid-frame with hold full and FIFO occupied
        m_tready = 1'b0;
        send(32'h6E, 0);
        send(32'h6F, 0);
        chk("t6_pre_valid", m_tvalid, 1);
        rst = 1'b1;
        idle(1);
        chk("t6_rst_valid", m_tvalid, 0);
        chk("t6_rst_frame", frame_cnt, 0);
        rst = 1'b0;
        m_tready = 1'b1;
        push(32'h61, 0); push(32'h62, 1);
        send(32'h61, 0);
        send(32'h62, 0);
        send(32'd7, 1);
        chk("t6_pkt", pkt_cnt, 2);
        chk("t6_seq", seq_err, 0);
        chk("t6_frame", frame_cnt, 1);
        idle(4);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_empty", m_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
